// File: rtl/modred_final_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | modred_final_pkg : shared widths and types for the reduction output  |
// | stage of the word-level modular reduction chain.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package modred_final_pkg;

    localparam int c_data_size_arb = 32;
    localparam int c_modred_lat    = 4;

    localparam int c_err_range = 0;
    localparam int c_err_proto = 1;

    typedef struct packed {
        logic                       vld;
        logic [c_data_size_arb-1:0] data;
    } corr_t;

endpackage : modred_final_pkg
`default_nettype wire

// File: rtl/modred_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | modred_fifo : DEPTH-entry synchronous FIFO with a registered         |
// | first-word-fall-through head; full/empty decided by level only.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module modred_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_lw = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_lw-1:0]  level_q, level_d;
    logic [c_lw-1:0]  w_level_after_pop;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             w_do_push, w_do_pop;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(DEPTH - 1)) ? '0 : p + c_pw'(1);
    endfunction

    always_comb begin
        w_do_pop          = valid_q && pop_i;
        // A push arriving at a full FIFO is discarded; live entries are never overwritten.
        w_do_push         = push_i && (level_q != c_lw'(DEPTH));
        w_level_after_pop = level_q - c_lw'(w_do_pop);
        level_d           = w_level_after_pop + c_lw'(w_do_push);
        rd_ptr_d          = w_do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d          = w_do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        valid_d           = (level_d != '0);
        data_d            = data_q;
        if (w_do_push && (w_level_after_pop == '0)) begin
            data_d = push_data_i;
        end else if (level_d != '0) begin
            data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign level_o = level_q;

endmodule : modred_fifo
`default_nettype wire

// File: rtl/modred_final.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | modred_final : output stage of the modular reduction chain; valid    |
// | alignment, final conditional subtract of q, credit-gated FIFO.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module modred_final
    import modred_final_pkg::*;
#(
    parameter int CURR_DATA = 34,
    parameter int PIPE_LAT  = c_modred_lat,
    parameter int DEPTH     = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [c_data_size_arb-1:0] q_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [CURR_DATA-1:0]       c_i,
    output logic [c_data_size_arb-1:0] out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [1:0]                 err_o
);
    localparam int c_dw = c_data_size_arb;
    localparam int c_cw = $clog2(DEPTH + PIPE_LAT + 2) + 1;
    localparam int c_qpad = CURR_DATA + 1 - c_dw;

    logic [PIPE_LAT-1:0]  vld_sr_q, vld_sr_d;
    corr_t                corr_q, corr_d;
    logic [1:0]           err_q, err_d;
    logic                 w_tap;
    logic [CURR_DATA:0]   w_diff;
    logic [CURR_DATA+1:0] w_c_ext, w_two_q;
    logic [c_cw-1:0]      w_inflight, w_credit_used;
    logic                 w_unused_diff;

    generate
        if (PIPE_LAT > 1) begin : g_sr_multi
            assign vld_sr_d = {vld_sr_q[PIPE_LAT-2:0], in_valid_i};
        end else begin : g_sr_single
            assign vld_sr_d = in_valid_i;
        end
    endgenerate

    assign w_tap = vld_sr_q[PIPE_LAT-1];

    always_comb begin
        w_diff      = {1'b0, c_i} - {{c_qpad{1'b0}}, q_i};
        w_c_ext     = {2'b00, c_i};
        w_two_q     = {{c_qpad{1'b0}}, q_i, 1'b0};
        corr_d.vld  = w_tap;
        corr_d.data = corr_q.data;
        // A negative difference (sign bit set) means C was already below q.
        if (w_tap) begin
            corr_d.data = w_diff[CURR_DATA] ? c_i[c_dw-1:0] : w_diff[c_dw-1:0];
        end
        err_d = err_q;
        if (w_tap && (w_c_ext >= w_two_q)) begin
            err_d[c_err_range] = 1'b1;
        end
        if (in_valid_i && !in_ready_o) begin
            err_d[c_err_proto] = 1'b1;
        end
    end

    assign w_unused_diff = ^w_diff;

    // Every accepted sample holds a credit until it is popped from the FIFO.
    always_comb begin
        w_inflight = c_cw'(corr_q.vld);
        for (int i = 0; i < PIPE_LAT; i++) begin
            w_inflight = w_inflight + c_cw'(vld_sr_q[i]);
        end
        w_credit_used = c_cw'(level_o) + w_inflight;
        in_ready_o    = (w_credit_used < c_cw'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_sr_q <= '0;
            corr_q   <= '0;
            err_q    <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
            corr_q   <= corr_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;

    modred_fifo #(
        .WIDTH (c_dw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (corr_q.vld),
        .push_data_i (corr_q.data),
        .pop_i       (out_ready_i),
        .data_o      (out_data_o),
        .valid_o     (out_valid_o),
        .level_o     (level_o)
    );

endmodule : modred_final
`default_nettype wire

// File: tb/tb_modred_final.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_modred_final : randomized self-checking bench for modred_final    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_modred_final;
    import modred_final_pkg::*;

    localparam int CD = 34;
    localparam int PL = 4;
    localparam int DP = 4;
    localparam int DW = c_data_size_arb;
    localparam int LW = $clog2(DP + 1);
    localparam longint unsigned QV = 12289;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [DW-1:0] q_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [CD-1:0] c_i;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [LW-1:0] level_o;
    logic [1:0]    err_o;

    modred_final #(
        .CURR_DATA (CD),
        .PIPE_LAT  (PL),
        .DEPTH     (DP)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .q_i         (q_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .c_i         (c_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .level_o     (level_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            outstanding = 0;
    int            n_out = 0;
    logic [CD-1:0] c_sched [0:1023];
    bit            c_has   [0:1023];
    logic [DW-1:0] exp_q [$];
    logic [1:0]    err_exp = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [DW-1:0] ref_red(input logic [CD-1:0] c);
        longint unsigned v;
        v = longint'(c);
        if (v >= QV) v = v - QV;
        return v[DW-1:0];
    endfunction

    function automatic logic [CD-1:0] rand_c(input int unsigned hi);
        return CD'($urandom_range(0, hi));
    endfunction

    // One clock cycle: observe outputs, drive inputs, advance to just after the next edge.
    task automatic step(input bit v, input logic [CD-1:0] cv, input bit rdy);
        logic [63:0] junk;
        int          idx;
        check_eq("in_ready", in_ready_o, (outstanding < DP));
        if (out_valid_o && rdy) begin
            if (exp_q.size() == 0) check_eq("unexpected_out", out_valid_o, 1'b0);
            else check_eq("out_data", out_data_o, exp_q.pop_front());
            n_out++;
            outstanding--;
        end else if (out_valid_o && exp_q.size() > 0) begin
            check_eq("head_hold", out_data_o, exp_q[0]);
        end
        idx  = cyc % 1024;
        junk = {$urandom(), $urandom()};
        c_i  = c_has[idx] ? c_sched[idx] : junk[CD-1:0];
        c_has[idx] = 1'b0;
        in_valid_i  = v;
        out_ready_i = rdy;
        if (v) begin
            c_sched[(cyc + PL) % 1024] = cv;
            c_has[(cyc + PL) % 1024]   = 1'b1;
            if (in_ready_o) begin
                exp_q.push_back(ref_red(cv));
                outstanding++;
                if (longint'(cv) >= 2 * QV) err_exp[0] = 1'b1;
            end else begin
                err_exp[1] = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, '0, rdy);
    endtask

    task automatic do_reset(input int n);
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        reset_i = 1'b0;
        exp_q.delete();
        outstanding = 0;
        err_exp     = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat, acc, out0;
        q_i = DW'(QV);
        c_i = '0;
        for (int i = 0; i < 1024; i++) c_has[i] = 1'b0;
        do_reset(2);
        check_eq("rst_out_valid", out_valid_o, 1'b0);
        check_eq("rst_out_data", out_data_o, '0);
        check_eq("rst_level", level_o, '0);
        check_eq("rst_in_ready", in_ready_o, 1'b1);
        check_eq("rst_err", err_o, '0);

        // Single sample latency and correction.
        idle(3, 1'b1);
        t0 = cyc;
        step(1'b1, CD'(12290), 1'b1);
        lat = -1;
        for (int k = 0; k < 12 && lat < 0; k++) begin
            if (out_valid_o) lat = cyc - t0;
            else step(1'b0, '0, 1'b1);
        end
        check_eq("single_latency", 64'(lat), 64'(PL + 2));
        check_eq("single_data", out_data_o, 64'd1);
        idle(3, 1'b1);
        check_eq("single_err", err_o, err_exp);

        // Boundary values back to back.
        step(1'b1, CD'(0), 1'b1);
        step(1'b1, CD'(12288), 1'b1);
        step(1'b1, CD'(12289), 1'b1);
        step(1'b1, CD'(24577), 1'b1);
        idle(10, 1'b1);
        check_eq("bound_err", err_o, err_exp);
        check_eq("bound_count", n_out, 5);

        // Range error is sticky.
        step(1'b1, CD'(24578), 1'b1);
        idle(8, 1'b1);
        check_eq("range_err", err_o, err_exp);
        idle(5, 1'b1);
        check_eq("range_sticky", err_o[0], 1'b1);

        // Back-pressure: upstream obeys in_ready, consumer stalled.
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            if (in_ready_o) acc++;
            step(in_ready_o, rand_c(2 * 12289 - 1), 1'b0);
        end
        check_eq("bp_accepted", acc, DP);
        check_eq("bp_level", level_o, DP);
        check_eq("bp_in_ready", in_ready_o, 1'b0);
        // Protocol violation: flagged and dropped at the full FIFO.
        step(1'b1, CD'(5), 1'b0);
        idle(8, 1'b0);
        check_eq("proto_level", level_o, DP);
        check_eq("proto_err", err_o, err_exp);
        out0 = n_out;
        idle(10, 1'b1);
        check_eq("bp_drained", n_out - out0, DP);
        check_eq("bp_level_empty", level_o, '0);
        check_eq("bp_ready_back", in_ready_o, 1'b1);
        do_reset(1);
        check_eq("err_cleared", err_o, '0);

        // Concurrent push/pop with two entries buffered; 20 more samples wrap the pointers.
        step(1'b1, rand_c(2 * 12289 - 1), 1'b0);
        step(1'b1, rand_c(2 * 12289 - 1), 1'b0);
        idle(6, 1'b0);
        check_eq("pp_level2", level_o, 2);
        out0 = n_out;
        acc  = 0;
        for (int k = 0; k < 400 && acc < 20; k++) begin
            if (in_ready_o) acc++;
            step(in_ready_o, rand_c(2 * 12289 - 1), 1'b1);
            check_eq("pp_level_le2", (level_o <= 2), 1'b1);
        end
        check_eq("pp_accepted", acc, 20);
        idle(12, 1'b1);
        check_eq("pp_no_loss", n_out - out0, 22);

        // Randomized traffic with occasional out-of-range C.
        for (int k = 0; k < 300; k++) begin
            step(in_ready_o & 1'($urandom()), rand_c(3 * 12289), 1'($urandom()));
        end
        idle(15, 1'b1);
        check_eq("rand_err", err_o, err_exp);
        check_eq("rand_empty", level_o, '0);

        // Reset with two buffered and two in flight (plus one violating sample).
        step(1'b1, rand_c(2 * 12289 - 1), 1'b0);
        step(1'b1, rand_c(2 * 12289 - 1), 1'b0);
        idle(5, 1'b0);
        check_eq("mid_level2", level_o, 2);
        step(1'b1, rand_c(2 * 12289 - 1), 1'b0);
        step(1'b1, rand_c(2 * 12289 - 1), 1'b0);
        step(1'b1, rand_c(2 * 12289 - 1), 1'b0);
        do_reset(1);
        check_eq("mid_out_valid", out_valid_o, 1'b0);
        check_eq("mid_level", level_o, '0);
        check_eq("mid_in_ready", in_ready_o, 1'b1);
        check_eq("mid_err", err_o, '0);
        for (int k = 0; k < 12; k++) begin
            check_eq("mid_no_stale", out_valid_o, 1'b0);
            step(1'b0, '0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_modred_final
`default_nettype wire
